// File: rtl/qoi_stream_framer.sv
// QOI file framer: wraps the encoder's chunk-byte stream with the 14-byte header
// and the 8-byte end marker, driving a registered valid/ready byte output.
module qoi_stream_framer #(
  parameter logic [7:0] CHANNELS   = 8'd4,
  parameter logic [7:0] COLORSPACE = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] width_i,
  input  logic [31:0] height_i,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] byte_count
);

  typedef enum logic [2:0] {IDLE, HEADER, BODY, TRAILER, DRAIN} state_t;

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic [31:0] width_q, height_q;
  logic [7:0]  hdr_byte, data_nx;
  logic        valid_nx, lat, ld, hs;

  assign ld = !out_valid || out_ready;
  assign hs = out_valid && out_ready;

  always_comb begin
    hdr_byte = 8'h00;
    case (idx)
      4'd0:  hdr_byte = 8'h71;
      4'd1:  hdr_byte = 8'h6F;
      4'd2:  hdr_byte = 8'h69;
      4'd3:  hdr_byte = 8'h66;
      4'd4:  hdr_byte = width_q[31:24];
      4'd5:  hdr_byte = width_q[23:16];
      4'd6:  hdr_byte = width_q[15:8];
      4'd7:  hdr_byte = width_q[7:0];
      4'd8:  hdr_byte = height_q[31:24];
      4'd9:  hdr_byte = height_q[23:16];
      4'd10: hdr_byte = height_q[15:8];
      4'd11: hdr_byte = height_q[7:0];
      4'd12: hdr_byte = CHANNELS;
      4'd13: hdr_byte = COLORSPACE;
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    data_nx  = out_data;
    // a handshake with nothing new to load empties the output register
    valid_nx = out_valid && !out_ready;
    in_ready = 1'b0;
    done     = 1'b0;
    lat      = 1'b0;
    case (state)
      IDLE: if (start) begin
        lat      = 1'b1;
        idx_nx   = 4'd0;
        state_nx = HEADER;
      end
      HEADER: if (ld) begin
        data_nx  = hdr_byte;
        valid_nx = 1'b1;
        if (idx == 4'd13) begin
          state_nx = BODY;
          idx_nx   = 4'd0;
        end else idx_nx = idx + 4'd1;
      end
      BODY: begin
        in_ready = ld;
        if (in_valid && ld) begin
          data_nx  = in_data;
          valid_nx = 1'b1;
          if (in_last) begin
            state_nx = TRAILER;
            idx_nx   = 4'd0;
          end
        end
      end
      TRAILER: if (ld) begin
        data_nx  = (idx == 4'd7) ? 8'h01 : 8'h00;
        valid_nx = 1'b1;
        if (idx == 4'd7) begin
          state_nx = DRAIN;
          idx_nx   = 4'd0;
        end else idx_nx = idx + 4'd1;
      end
      DRAIN: if (hs) begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // start during the done cycle is ignored because state is still DRAIN
  assign busy = (state != IDLE) && !done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      idx        <= 4'd0;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      byte_count <= 32'd0;
      width_q    <= 32'd0;
      height_q   <= 32'd0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      out_data  <= data_nx;
      out_valid <= valid_nx;
      if (lat) begin
        width_q    <= width_i;
        height_q   <= height_i;
        byte_count <= 32'd0;
      end else if (hs) byte_count <= byte_count + 32'd1;
    end
  end

endmodule
